// File: rtl/picobello_pkg.sv
// Shared picobello constants: cluster count, cluster IRQ controller register map and types.
package picobello_pkg;

  localparam int unsigned NumClusters = 6;

  localparam int unsigned IrqPendingOffs = 32'h00;
  localparam int unsigned IrqSetOffs     = 32'h04;
  localparam int unsigned IrqClearOffs   = 32'h08;
  localparam int unsigned IrqEnableOffs  = 32'h0C;
  localparam int unsigned IrqStatusOffs  = 32'h10;
  localparam int unsigned IrqCntBaseOffs = 32'h40;

  localparam int unsigned IrqCntWidth = 16;
  typedef logic [IrqCntWidth-1:0] irq_cnt_t;

  typedef enum logic {IrqIdle, IrqResp} irq_state_e;

endpackage

// File: rtl/picobello_irq_counter.sv
// Saturating per-line event counter; only built when PICOBELLO_IRQ_COUNTER_EN is defined.
`ifdef PICOBELLO_IRQ_COUNTER_EN
module picobello_irq_counter import picobello_pkg::*; (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   inc_i,
  input  logic                   clr_i,
  output logic [IrqCntWidth-1:0] cnt_o
);

  irq_cnt_t cnt_q, cnt_d;

  // A clear racing an event keeps that event, so the count restarts at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                      cnt_d = irq_cnt_t'(inc_i);
    else if (inc_i && cnt_q != '1)  cnt_d = cnt_q + irq_cnt_t'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/picobello_cluster_irq_ctrl.sv
// Per-cluster pending/enable interrupt controller on a 32-bit register port.
// Optional per-line event counters at 0x40+4*i with PICOBELLO_IRQ_COUNTER_EN.
module picobello_cluster_irq_ctrl import picobello_pkg::*; #(
  parameter int unsigned NumIrq    = picobello_pkg::NumClusters,
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [31:0]          req_wdata_i,
  input  logic [3:0]           req_wstrb_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o,
  input  logic [NumIrq-1:0]    hw_set_i,
  output logic [NumIrq-1:0]    irq_o
);

  irq_state_e           state_q, state_d;
  logic [NumIrq-1:0]    pending_q, pending_d, enable_q, enable_d, irq_q;
  logic [31:0]          rdata_q, rdata_d, bm, wmask, rd_val;
  logic                 err_q, err_d, hs, en_wr, dec_err;
  logic [AddrWidth-1:0] addr_w;
  logic [NumIrq-1:0]    wbits, set_w, clr_w;
  logic                 unused_bits;

  assign unused_bits = ^req_addr_i[1:0] ^ ^req_wdata_i ^ ^bm ^ ^wmask;

  assign addr_w = {req_addr_i[AddrWidth-1:2], 2'b00};
  assign hs     = req_valid_i && (state_q == IrqIdle);

  always_comb begin
    for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{req_wstrb_i[b]}};
  end
  assign wmask = req_wdata_i & bm;
  assign wbits = wmask[NumIrq-1:0];

`ifdef PICOBELLO_IRQ_COUNTER_EN
  irq_cnt_t [NumIrq-1:0] cnt;
  logic     [NumIrq-1:0] cnt_clr;

  for (genvar i = 0; i < NumIrq; i++) begin : g_cnt
    picobello_irq_counter u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (hw_set_i[i] | set_w[i]),
      .clr_i  (cnt_clr[i]),
      .cnt_o  (cnt[i])
    );
  end
`endif

  // Address decode; side-effect strobes are qualified by the handshake.
  always_comb begin
    rd_val  = '0;
    dec_err = 1'b0;
    set_w   = '0;
    clr_w   = '0;
    en_wr   = 1'b0;
`ifdef PICOBELLO_IRQ_COUNTER_EN
    cnt_clr = '0;
`endif
    if (addr_w == AddrWidth'(IrqPendingOffs)) begin
      rd_val  = 32'(pending_q);
      dec_err = req_write_i;
    end else if (addr_w == AddrWidth'(IrqSetOffs)) begin
      if (hs && req_write_i) set_w = wbits;
    end else if (addr_w == AddrWidth'(IrqClearOffs)) begin
      if (hs && req_write_i) clr_w = wbits;
    end else if (addr_w == AddrWidth'(IrqEnableOffs)) begin
      rd_val = 32'(enable_q);
      en_wr  = hs && req_write_i;
    end else if (addr_w == AddrWidth'(IrqStatusOffs)) begin
      rd_val  = 32'(pending_q & enable_q);
      dec_err = req_write_i;
    end else begin
`ifdef PICOBELLO_IRQ_COUNTER_EN
      dec_err = 1'b1;
      for (int i = 0; i < NumIrq; i++) begin
        if (addr_w == AddrWidth'(IrqCntBaseOffs + 4 * i)) begin
          dec_err    = 1'b0;
          rd_val     = 32'(cnt[i]);
          cnt_clr[i] = hs && req_write_i;
        end
      end
`else
      dec_err = 1'b1;
`endif
    end
  end

  // Hardware events are OR-ed in last so they beat a same-cycle CLEAR.
  always_comb begin
    pending_d = ((pending_q | set_w) & ~clr_w) | hw_set_i;
    enable_d  = en_wr ? ((enable_q & ~bm[NumIrq-1:0]) | wbits) : enable_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    state_d   = state_q;
    unique case (state_q)
      IrqIdle: if (hs) begin
        rdata_d = (req_write_i || dec_err) ? '0 : rd_val;
        err_d   = dec_err;
        state_d = IrqResp;
      end
      IrqResp: if (rsp_ready_i) state_d = IrqIdle;
      default: state_d = IrqIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IrqIdle;
      pending_q <= '0;
      enable_q  <= '0;
      irq_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_q     <= pending_q & enable_q;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  assign req_ready_o = (state_q == IrqIdle);
  assign rsp_valid_o = (state_q == IrqResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_picobello_cluster_irq_ctrl.sv
// Self-checking bench for picobello_cluster_irq_ctrl: register table plus timing/reset/counter sequences.
module tb_picobello_cluster_irq_ctrl;
  import picobello_pkg::*;

  localparam int N = NumClusters;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [7:0]    req_addr = '0;
  logic [31:0]   req_wdata = '0, rsp_rdata;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [N-1:0]  hw_set = '0, irq;

  picobello_cluster_irq_ctrl #(.NumIrq(N), .AddrWidth(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err), .hw_set_i(hw_set), .irq_o(irq)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic err; } exp_t;
  typedef struct {
    string nm; logic [7:0] a; logic w; logic [31:0] d; logic [3:0] s;
    logic [31:0] er; logic ee;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   errors = 0, checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Entered and left at #1 after a rising edge; returns just after the handshake edge.
  task automatic issue(input logic [7:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [N-1:0] hw);
    int n = 0;
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_wstrb = s; hw_set = hw;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) check("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; hw_set = '0;
  endtask

  task automatic collect(input string nm);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    check({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({nm, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({nm, "_rdata"}, rsp_rdata, e.rdata);
      check({nm, "_err"}, 32'(rsp_err), 32'(e.err));
    end
    @(posedge clk); #1;
  endtask

  task automatic access(input string nm, input logic [7:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] er, input logic ee,
                        input logic [N-1:0] hw);
    exp_q.push_back('{rdata: er, err: ee});
    issue(a, w, d, s, hw);
    collect(nm);
  endtask

  function automatic void add(input string nm, input logic [7:0] a, input logic w,
                              input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] er, input logic ee);
    tbl.push_back('{nm: nm, a: a, w: w, d: d, s: s, er: er, ee: ee});
  endfunction

  initial begin
    add("rd_en_rst",  8'h0C, 0, 32'h0,        4'hF, 32'h00, 0);
    add("w_en",       8'h0C, 1, 32'h3F,       4'hF, 32'h00, 0);
    add("rd_en",      8'h0C, 0, 32'h0,        4'hF, 32'h3F, 0);
    add("w_set",      8'h04, 1, 32'h05,       4'hF, 32'h00, 0);
    add("rd_stat",    8'h10, 0, 32'h0,        4'hF, 32'h05, 0);
    add("rd_pend",    8'h00, 0, 32'h0,        4'hF, 32'h05, 0);
    add("rd_set",     8'h04, 0, 32'h0,        4'hF, 32'h00, 0);
    add("rd_clr",     8'h08, 0, 32'h0,        4'hF, 32'h00, 0);
    add("w_clr",      8'h08, 1, 32'h01,       4'hF, 32'h00, 0);
    add("rd_pend2",   8'h00, 0, 32'h0,        4'hF, 32'h04, 0);
    add("w_en_hi",    8'h0E, 1, 32'hFFFFFF00, 4'hE, 32'h00, 0);
    add("rd_en_hi",   8'h0C, 0, 32'h0,        4'hF, 32'h3F, 0);
    add("w_en_lo",    8'h0C, 1, 32'hFFFFFF16, 4'h1, 32'h00, 0);
    add("rd_en_lo",   8'h0C, 0, 32'h0,        4'hF, 32'h16, 0);
    add("rd_stat2",   8'h10, 0, 32'h0,        4'hF, 32'h04, 0);
    add("w_set_all",  8'h04, 1, 32'hFFFFFFFF, 4'hF, 32'h00, 0);
    add("rd_pend_all",8'h00, 0, 32'h0,        4'hF, 32'h3F, 0);
    add("w_ro_pend",  8'h00, 1, 32'h0,        4'hF, 32'h00, 1);
    add("w_ro_stat",  8'h10, 1, 32'h0,        4'hF, 32'h00, 1);
    add("rd_3c",      8'h3C, 0, 32'h0,        4'hF, 32'h00, 1);
    add("rd_14",      8'h14, 0, 32'h0,        4'hF, 32'h00, 1);
    add("rd_pend_ro", 8'h00, 0, 32'h0,        4'hF, 32'h3F, 0);
    add("w_clr_all",  8'h08, 1, 32'hFFFFFFFF, 4'hF, 32'h00, 0);
    add("rd_pend_0",  8'h00, 0, 32'h0,        4'hF, 32'h00, 0);
    add("w_set_nostb",8'h04, 1, 32'hFFFFFFFF, 4'h0, 32'h00, 0);
    add("rd_pend_ns", 8'h00, 0, 32'h0,        4'hF, 32'h00, 0);
`ifdef PICOBELLO_IRQ_COUNTER_EN
    add("rd_cnt0",    8'h40, 0, 32'h0,        4'hF, 32'h02, 0);
`else
    add("rd_cnt0",    8'h40, 0, 32'h0,        4'hF, 32'h00, 1);
`endif
    add("rd_58",      8'h58, 0, 32'h0,        4'hF, 32'h00, 1);
    add("w_en_3f",    8'h0C, 1, 32'h3F,       4'hF, 32'h00, 0);

    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i])
      access(tbl[i].nm, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].s, tbl[i].er, tbl[i].ee, '0);

    // SET write lands at handshake edge N, irq follows at N+1
    exp_q.push_back('{rdata: 32'h0, err: 1'b0});
    issue(8'h04, 1, 32'h05, 4'hF, '0);
    check("irq_at_N", 32'(irq), 32'h00);
    collect("w_set_irq");
    check("irq_at_N1", 32'(irq), 32'h05);

    // hw set beats a same-cycle CLEAR
    access("w_clr_all2", 8'h08, 1, 32'hFF, 4'hF, 32'h0, 0, '0);
    access("w_clr_hw2", 8'h08, 1, 32'h04, 4'hF, 32'h0, 0, N'(6'h04));
    access("rd_setwins", 8'h00, 0, 32'h0, 4'hF, 32'h04, 0, '0);

    // read excludes a same-cycle pulse, next read sees it
    access("rd_hw_same", 8'h00, 0, 32'h0, 4'hF, 32'h04, 0, N'(6'h02));
    access("rd_hw_next", 8'h00, 0, 32'h0, 4'hF, 32'h06, 0, '0);

    // pulse-to-irq latency of two edges
    check("irq_before_pulse", 32'(irq), 32'h06);
    hw_set = N'(6'h08);
    @(posedge clk); #1; hw_set = '0;
    check("irq_pulse_e1", 32'(irq), 32'h06);
    @(posedge clk); #1;
    check("irq_pulse_e2", 32'(irq), 32'h0E);

    // stalled response holds; reset mid-transaction drops it
    rsp_ready = 1'b0;
    issue(8'h0C, 0, 32'h0, 4'hF, '0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("stall%0d_rdata", c), rsp_rdata, 32'h3F);
      check($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rdata", rsp_rdata, 32'd0);
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_irq", 32'(irq), 32'd0);
    @(negedge clk); rst_n = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    access("rd_en_after_rst", 8'h0C, 0, 32'h0, 4'hF, 32'h0, 0, '0);
    access("rd_pend_after_rst", 8'h00, 0, 32'h0, 4'hF, 32'h0, 0, '0);

`ifdef PICOBELLO_IRQ_COUNTER_EN
    hw_set = N'(6'h01);
    repeat (70000) @(posedge clk);
    #1 hw_set = '0;
    access("rd_cnt_sat", 8'h40, 0, 32'h0, 4'hF, 32'h0000FFFF, 0, '0);
    access("rd_cnt1_0", 8'h44, 0, 32'h0, 4'hF, 32'h0, 0, '0);
    access("w_cnt_clr", 8'h40, 1, 32'h0, 4'hF, 32'h0, 0, '0);
    access("rd_cnt_clr", 8'h40, 0, 32'h0, 4'hF, 32'h0, 0, '0);
    access("w_cnt_clr_hw", 8'h40, 1, 32'h0, 4'hF, 32'h0, 0, N'(6'h01));
    access("rd_cnt_one", 8'h40, 0, 32'h0, 4'hF, 32'h1, 0, '0);
`endif

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
